// File: rtl/rmii_pkg.sv
// rmii_pkg: shared state encoding and framing constants for the RMII transmit scheduler
package rmii_pkg;
  typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, PAYLOAD, IFG} sched_state_t;
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter; the pointer favours the source not granted last
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);
  logic ptr_q;
  // pointer only breaks ties; a lone requester always wins
  always_comb gnt = (&req) ? (ptr_q ? 2'b10 : 2'b01) : (req[0] ? 2'b01 : {req[1], 1'b0});
  // after granting s0 the pointer favours s1, and vice versa
  always_ff @(posedge clk)
    if (reset) ptr_q <= 1'b0;
    else if (en && |req) ptr_q <= gnt[0];
endmodule

// File: rtl/rmii_tx_scheduler.sv
// rmii_tx_scheduler: frame arbiter adding preamble/SFD and inter-frame gap ahead of the RMII serializer
module rmii_tx_scheduler
  import rmii_pkg::*;
#(
  parameter int BW = 8,
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_CYCLES = 48
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [BW-1:0] s0_axis_tdata,
  input  logic          s0_axis_tvalid,
  input  logic          s0_axis_tlast,
  output logic          s0_axis_tready,
  input  logic [BW-1:0] s1_axis_tdata,
  input  logic          s1_axis_tvalid,
  input  logic          s1_axis_tlast,
  output logic          s1_axis_tready,
  output logic [BW-1:0] m_axis_tdata,
  output logic          m_axis_tvalid,
  output logic          m_axis_tlast,
  input  logic          m_axis_tready,
  output logic [1:0]    grant,
  output logic          busy,
  output logic [15:0]   tx_frame_cnt
);
  sched_state_t state_q;
  logic [1:0] grant_q, arb_gnt;
  logic [7:0] cnt_q;
  logic [15:0] frame_cnt_q;
  logic [BW-1:0] src_data;
  logic src_valid, src_last, m_hs;
  rr_arbiter2 u_arb (
    .clk(clk),
    .reset(reset),
    .req({s1_axis_tvalid, s0_axis_tvalid}),
    .en(state_q == IDLE),
    .gnt(arb_gnt)
  );
  // granted source selection and state-driven output mux; payload is a pure pass-through
  always_comb begin
    src_data = grant_q[1] ? s1_axis_tdata : s0_axis_tdata;
    src_valid = grant_q[1] ? s1_axis_tvalid : s0_axis_tvalid;
    src_last = grant_q[1] ? s1_axis_tlast : s0_axis_tlast;
    m_axis_tvalid = (state_q == PREAMBLE || state_q == SFD) ? 1'b1 : (state_q == PAYLOAD) ? src_valid : 1'b0;
    m_axis_tdata = (state_q == PREAMBLE) ? PREAMBLE_BYTE : (state_q == SFD) ? SFD_BYTE : (state_q == PAYLOAD) ? src_data : '0;
    m_axis_tlast = (state_q == PAYLOAD) && src_last;
    s0_axis_tready = (state_q == PAYLOAD) && grant_q[0] && m_axis_tready;
    s1_axis_tready = (state_q == PAYLOAD) && grant_q[1] && m_axis_tready;
    m_hs = m_axis_tvalid && m_axis_tready;
    grant = grant_q;
    busy = state_q != IDLE;
    tx_frame_cnt = frame_cnt_q;
  end
  // frame FSM: one counter serves preamble beats and gap cycles
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      cnt_q <= 8'd0;
      frame_cnt_q <= 16'd0;
    end else
      case (state_q)
        IDLE:
          if (|arb_gnt) begin
            state_q <= PREAMBLE;
            grant_q <= arb_gnt;
            cnt_q <= 8'd0;
          end
        PREAMBLE:
          if (m_hs) begin
            cnt_q <= (cnt_q == 8'(PREAMBLE_LEN - 1)) ? 8'd0 : cnt_q + 8'd1;
            if (cnt_q == 8'(PREAMBLE_LEN - 1)) state_q <= SFD;
          end
        SFD:
          if (m_hs) state_q <= PAYLOAD;
        PAYLOAD:
          if (m_hs && m_axis_tlast) begin
            state_q <= IFG;
            grant_q <= 2'b00;
            cnt_q <= 8'd0;
            frame_cnt_q <= frame_cnt_q + 16'd1;
          end
        IFG: begin
          cnt_q <= cnt_q + 8'd1;
          if (cnt_q == 8'(IFG_CYCLES - 1)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
endmodule
